mem_port_arbiter: RTL and testbench

Shares one downstream word-wide memory port between the CPU's instruction requester and data requester. Sits between the cpu core's inst_mem_*/data_mem_* interfaces and a single physical/L2 memory port. Data requests have priority; a starvation counter bounds instruction wait. Each requester sees the same read/write/resp handshake it would see from a private memory.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the inst and data requesters.
// Data has priority, bounded by a starvation counter; define ARB_PERF_CNT_EN to add perf counters.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   inst_mem_address,
    input  logic                    inst_mem_read,
    input  logic                    inst_mem_write,
    input  logic [DATA_WIDTH/8-1:0] inst_mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   inst_mem_wdata,
    output logic [DATA_WIDTH-1:0]   inst_mem_rdata,
    output logic                    inst_mem_resp,
    input  logic [DATA_WIDTH-1:0]   data_mem_address,
    input  logic                    data_mem_read,
    input  logic                    data_mem_write,
    input  logic [DATA_WIDTH/8-1:0] data_mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   data_mem_wdata,
    output logic [DATA_WIDTH-1:0]   data_mem_rdata,
    output logic                    data_mem_resp,
    output logic [DATA_WIDTH-1:0]   pmem_address,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]             perf_inst_grants,
    output logic [31:0]             perf_data_grants,
    output logic [31:0]             perf_conflict_cycles,
`endif
    input  logic [DATA_WIDTH-1:0]   pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]            state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  done_data_q, done_data_d;
    logic [DATA_WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [BE_W-1:0]       pmem_be_q, pmem_be_d;
    logic [DATA_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

    logic inst_pend;
    logic data_pend;
    logic grant_inst;
    logic grant_data;

    assign inst_pend  = inst_mem_read | inst_mem_write;
    assign data_pend  = data_mem_read | data_mem_write;
    // Inst only overtakes a pending data request once it has been passed over STARVE_LIMIT times.
    assign grant_inst = (state_q == IDLE) && inst_pend && (!data_pend || (starve_q == STARVE_MAX));
    assign grant_data = (state_q == IDLE) && data_pend && !grant_inst;

    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        done_data_d    = done_data_q;
        pmem_address_d = pmem_address_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_be_d      = pmem_be_q;
        pmem_wdata_d   = pmem_wdata_q;
        inst_rdata_d   = inst_rdata_q;
        data_rdata_d   = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_inst) begin
                    pmem_address_d = inst_mem_address;
                    pmem_read_d    = inst_mem_read;
                    pmem_write_d   = inst_mem_write & ~inst_mem_read;
                    pmem_be_d      = inst_mem_byte_enable;
                    pmem_wdata_d   = inst_mem_wdata;
                    starve_d       = '0;
                    state_d        = SERVE_I;
                end else if (grant_data) begin
                    pmem_address_d = data_mem_address;
                    pmem_read_d    = data_mem_read;
                    pmem_write_d   = data_mem_write & ~data_mem_read;
                    pmem_be_d      = data_mem_byte_enable;
                    pmem_wdata_d   = data_mem_wdata;
                    if (inst_pend && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d        = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    // Write completions leave the requester's last read data untouched.
                    if (pmem_read_q) begin
                        if (state_q == SERVE_I) begin
                            inst_rdata_d = pmem_rdata;
                        end else begin
                            data_rdata_d = pmem_rdata;
                        end
                    end
                    done_data_d = (state_q == SERVE_D);
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            done_data_q    <= 1'b0;
            pmem_address_q <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_be_q      <= '0;
            pmem_wdata_q   <= '0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            done_data_q    <= done_data_d;
            pmem_address_q <= pmem_address_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_be_q      <= pmem_be_d;
            pmem_wdata_q   <= pmem_wdata_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign pmem_address     = pmem_address_q;
    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_byte_enable = pmem_be_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign inst_mem_rdata   = inst_rdata_q;
    assign data_mem_rdata   = data_rdata_q;
    assign inst_mem_resp    = (state_q == DONE) && !done_data_q;
    assign data_mem_resp    = (state_q == DONE) && done_data_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_grants_q, inst_grants_d;
    logic [31:0] data_grants_q, data_grants_d;
    logic [31:0] conflicts_q, conflicts_d;

    always_comb begin
        inst_grants_d = inst_grants_q;
        data_grants_d = data_grants_q;
        conflicts_d   = conflicts_q;
        if (grant_inst) begin
            inst_grants_d = inst_grants_q + 32'd1;
        end
        if (grant_data) begin
            data_grants_d = data_grants_q + 32'd1;
        end
        if (inst_pend && data_pend && (state_q != DONE)) begin
            conflicts_d = conflicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_grants_q <= '0;
            data_grants_q <= '0;
            conflicts_q   <= '0;
        end else begin
            inst_grants_q <= inst_grants_d;
            data_grants_q <= data_grants_d;
            conflicts_q   <= conflicts_d;
        end
    end

    assign perf_inst_grants     = inst_grants_q;
    assign perf_data_grants     = data_grants_q;
    assign perf_conflict_cycles = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter; with ARB_PERF_CNT_EN defined it also
// checks the perf counters.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned DW      = 32;
    localparam int unsigned BW      = DW / 8;
    localparam int unsigned LIMIT   = 4;
    localparam int unsigned N_TXN   = 150;
    localparam int unsigned MAX_AGE = 100;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    logic          clk;
    logic          rst;
    req_t          inst_drv;
    req_t          data_drv;
    logic [DW-1:0] inst_mem_rdata, data_mem_rdata;
    logic          inst_mem_resp, data_mem_resp;
    logic [DW-1:0] pmem_address, pmem_wdata, pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [BW-1:0] pmem_byte_enable;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_inst_grants, perf_data_grants, perf_conflict_cycles;
`endif

    mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_mem_address     (inst_drv.addr),
        .inst_mem_read        (inst_drv.rd),
        .inst_mem_write       (inst_drv.wr),
        .inst_mem_byte_enable (inst_drv.be),
        .inst_mem_wdata       (inst_drv.wdata),
        .inst_mem_rdata       (inst_mem_rdata),
        .inst_mem_resp        (inst_mem_resp),
        .data_mem_address     (data_drv.addr),
        .data_mem_read        (data_drv.rd),
        .data_mem_write       (data_drv.wr),
        .data_mem_byte_enable (data_drv.be),
        .data_mem_wdata       (data_drv.wdata),
        .data_mem_rdata       (data_mem_rdata),
        .data_mem_resp        (data_mem_resp),
        .pmem_address         (pmem_address),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_byte_enable     (pmem_byte_enable),
        .pmem_wdata           (pmem_wdata),
`ifdef ARB_PERF_CNT_EN
        .perf_inst_grants     (perf_inst_grants),
        .perf_data_grants     (perf_data_grants),
        .perf_conflict_cycles (perf_conflict_cycles),
`endif
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    bit            abort = 1'b0;
    logic [DW-1:0] inst_q[$];
    logic [DW-1:0] data_q[$];
    logic [DW-1:0] mem[logic [DW-1:0]];
    logic [DW-1:0] shadow[logic [DW-1:0]];
    logic [DW-1:0] last_rd[2];
    bit            busy[2];
    int unsigned   cur_owner = 0;   // 0 none, 1 inst, 2 data: whose op is on the port
    int unsigned   starve_m = 0;
    int unsigned   ig_m = 0, dg_m = 0, cf_m = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [DW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < int'(BW); i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [135:0] all_outs();
        return {pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
                inst_mem_rdata, inst_mem_resp, data_mem_rdata, data_mem_resp};
    endfunction

    // Downstream memory: random 0..3 cycle latency, plus stray resp pulses while idle.
    initial begin : responder
        int wait_left;
        logic [DW-1:0] old;
        wait_left  = -1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst) begin
                wait_left = -1;
                continue;
            end
            if (pmem_read || pmem_write) begin
                if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    old = mem.exists(pmem_address) ? mem[pmem_address] : init_word(pmem_address);
                    if (pmem_read) begin
                        pmem_rdata = old;
                    end else begin
                        mem[pmem_address] = merge(old, pmem_wdata, pmem_byte_enable);
                        pmem_rdata = $urandom;
                    end
                    pmem_resp = 1'b1;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                pmem_rdata = $urandom;
                pmem_resp  = 1'b1;
            end
        end
    end

    // Downstream monitor: checks who was granted and what was captured, and keeps perf models.
    initial begin : pmem_mon
        req_t prev_i, prev_d, g;
        bit prev_active, active, ip, dp, to_data;
        logic [69:0] held, now;
        prev_active = 1'b0;
        prev_i = '0;
        prev_d = '0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                starve_m = 0; ig_m = 0; dg_m = 0; cf_m = 0;
                cur_owner = 0; prev_active = 1'b0;
                prev_i = inst_drv; prev_d = data_drv;
                continue;
            end
            active = pmem_read || pmem_write;
            now = {pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata};
            if (active && !prev_active) begin
                ip = prev_i.rd || prev_i.wr;
                dp = prev_d.rd || prev_d.wr;
                check("grant_had_request", {31'd0, ip || dp}, 160'd1);
                to_data = dp && !(ip && starve_m == LIMIT);
                g = to_data ? prev_d : prev_i;
                held = {g.rd, g.wr & ~g.rd, g.addr, g.be, g.wdata};
                check(to_data ? "grant_data_op" : "grant_inst_op", now, held);
                if (to_data) begin
                    dg_m++;
                    if (ip && starve_m < LIMIT) starve_m++;
                    cur_owner = 2;
                end else begin
                    ig_m++;
                    starve_m = 0;
                    cur_owner = 1;
                end
            end else if (active) begin
                check("pmem_op_stable", now, held);
            end else begin
                cur_owner = 0;
            end
            if ((inst_drv.rd || inst_drv.wr) && (data_drv.rd || data_drv.wr) &&
                !inst_mem_resp && !data_mem_resp) cf_m++;
            prev_i = inst_drv;
            prev_d = data_drv;
            prev_active = active;
        end
    end

    // Response scoreboard: every resp pulse pops that requester's oldest expectation.
    initial begin : resp_mon
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (inst_mem_resp) begin
                if (inst_q.size() == 0) begin
                    check("inst_resp_unexpected", {31'd0, inst_mem_resp}, 160'd0);
                end else begin
                    e = inst_q.pop_front();
                    check("inst_rdata", inst_mem_rdata, e);
                end
            end
            if (data_mem_resp) begin
                if (data_q.size() == 0) begin
                    check("data_resp_unexpected", {31'd0, data_mem_resp}, 160'd0);
                end else begin
                    e = data_q.pop_front();
                    check("data_rdata", data_mem_rdata, e);
                end
            end
        end
    end

    task automatic issue(input int unsigned k, input bit force_read);
        req_t r;
        int unsigned kind;
        logic [DW-1:0] cur;
        kind    = force_read ? 0 : $urandom_range(0, 3);
        r.rd    = (kind != 2);
        r.wr    = (kind >= 2);
        r.addr  = ((k == 1) ? 32'h0000_1000 : 32'h0000_0000) | (DW'($urandom_range(0, 15)) << 2);
        r.wdata = $urandom;
        r.be    = BW'($urandom_range(0, (1 << BW) - 1));
        cur = shadow.exists(r.addr) ? shadow[r.addr] : init_word(r.addr);
        if (r.rd) last_rd[k] = cur;
        else shadow[r.addr] = merge(cur, r.wdata, r.be);
        if (k == 0) begin
            inst_drv = r;
            inst_q.push_back(last_rd[k]);
        end else begin
            data_drv = r;
            data_q.push_back(last_rd[k]);
        end
        busy[k] = 1'b1;
    endtask

    task automatic run_phase(input int unsigned n);
        int unsigned issued[2], cool[2], age[2];
        bit finished, resp;
        issued = '{0, 0}; cool = '{0, 0}; age = '{0, 0};
        finished = 1'b0;
        for (int unsigned cyc = 0; cyc < 20000 && !abort && !finished; cyc++) begin
            @(posedge clk);
            #1;
            for (int unsigned k = 0; k < 2; k++) begin
                resp = (k == 0) ? inst_mem_resp : data_mem_resp;
                if (busy[k]) begin
                    if (resp) begin
                        busy[k] = 1'b0;
                        cool[k] = (k == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1);
                        if (k == 0) begin inst_drv.rd = 1'b0; inst_drv.wr = 1'b0; end
                        else begin data_drv.rd = 1'b0; data_drv.wr = 1'b0; end
                    end else begin
                        age[k]++;
                        if (age[k] > MAX_AGE) begin
                            n_cmp++; n_bad++; abort = 1'b1;
                            $display("FAIL resp_timeout: requester %0d waited %0d cycles, limit %0d", k, age[k], MAX_AGE);
                        end else if (cur_owner == k + 1 && $urandom_range(0, 2) == 0) begin
                            if (k == 0) begin inst_drv.addr = $urandom; inst_drv.wdata = $urandom; inst_drv.be = ~inst_drv.be; end
                            else begin data_drv.addr = $urandom; data_drv.wdata = $urandom; data_drv.be = ~data_drv.be; end
                        end
                    end
                end
                if (!busy[k] && issued[k] < n) begin
                    if (cool[k] == 0) begin
                        issue(k, 1'b0);
                        issued[k]++;
                        age[k] = 0;
                    end else begin
                        cool[k]--;
                    end
                end
            end
            finished = issued[0] >= n && issued[1] >= n && !busy[0] && !busy[1];
        end
        if (!finished && !abort) begin
            n_cmp++; n_bad++; abort = 1'b1;
            $display("FAIL phase_timeout: issued %0d/%0d, required %0d each", issued[0], issued[1], n);
        end
    endtask

    task automatic reset_mid_serve();
        int unsigned waited;
        waited = 0;
        issue(1, 1'b1);
        @(posedge clk);
        #1;
        while (!(cur_owner == 2 && pmem_read && !data_mem_resp) && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reached_serve_d", {31'd0, pmem_read}, 160'd1);
        #2 rst = 1'b1;
        #1 check("reset_mid_outputs", all_outs(), '0);
`ifdef ARB_PERF_CNT_EN
        check("reset_mid_perf", {perf_inst_grants, perf_data_grants, perf_conflict_cycles}, '0);
`endif
        inst_q.delete();
        data_q.delete();
        busy = '{1'b0, 1'b0};
        inst_drv = '0;
        data_drv = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b1;
        inst_drv = '0;
        data_drv = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        busy = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), '0);
        rst = 1'b0;
        run_phase(N_TXN);
        if (!abort) begin
            reset_mid_serve();
            run_phase(N_TXN / 2);
        end
        repeat (4) @(posedge clk);
        #1;
        check("inst_queue_drained", inst_q.size(), 160'd0);
        check("data_queue_drained", data_q.size(), 160'd0);
`ifdef ARB_PERF_CNT_EN
        check("perf_inst_grants", perf_inst_grants, ig_m);
        check("perf_data_grants", perf_data_grants, dg_m);
        check("perf_conflict_cycles", perf_conflict_cycles, cf_m);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
